// File: rtl/v_ex_stage.sv
// Execute stage: ID/EX register with operand forwarding into the ALU, and an
// EX/MEM register capturing the ALU result and flags, both valid/ready handshaked.
module v_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [REG_W-1:0]  in_rs1_addr,
  input  logic [REG_W-1:0]  in_rs2_addr,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [3:0]        in_alu_op,
  input  logic              in_use_pc,
  input  logic              in_use_imm,
  input  logic [REG_W-1:0]  in_rd_addr,
  input  logic              in_reg_we,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_Z,
  input  logic              alu_N,
  input  logic              alu_C,
  input  logic              alu_V,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_rd_addr,
  output logic              out_reg_we,
  output logic [3:0]        out_flags
);

  localparam logic [3:0] ALU_ADD = 4'd0;

  logic              vld_p1;
  logic [DATA_W-1:0] pc_p1;
  logic [REG_W-1:0]  rs1_addr_p1;
  logic [REG_W-1:0]  rs2_addr_p1;
  logic [DATA_W-1:0] rs1_data_p1;
  logic [DATA_W-1:0] rs2_data_p1;
  logic [DATA_W-1:0] imm_p1;
  logic [3:0]        op_p1;
  logic              use_pc_p1;
  logic              use_imm_p1;
  logic [REG_W-1:0]  rd_addr_p1;
  logic              reg_we_p1;

  logic              s2_advance;
  logic              accept;
  logic [DATA_W-1:0] fwd_rs1;
  logic [DATA_W-1:0] fwd_rs2;

  // EX/MEM beats writeback because it holds the younger producer; x0 never forwards.
  function automatic logic [DATA_W-1:0] forward_val(
    input logic [REG_W-1:0]  rs,
    input logic [DATA_W-1:0] latched,
    input logic              s2_we,
    input logic [REG_W-1:0]  s2_rd,
    input logic [DATA_W-1:0] s2_val,
    input logic              w_we,
    input logic [REG_W-1:0]  w_rd,
    input logic [DATA_W-1:0] w_val
  );
    logic [DATA_W-1:0] v;
    v = latched;
    if (rs != '0) begin
      if (s2_we && (s2_rd == rs)) v = s2_val;
      else if (w_we && (w_rd == rs)) v = w_val;
    end
    return v;
  endfunction

  assign s2_advance = vld_p1 && (!out_valid || out_ready);
  assign in_ready   = !vld_p1 || s2_advance || flush;
  assign accept     = in_valid && in_ready && !flush;

  always_comb begin
    fwd_rs1 = forward_val(rs1_addr_p1, rs1_data_p1, out_valid && out_reg_we, out_rd_addr,
                          out_result, wb_we, wb_rd, wb_data);
    fwd_rs2 = forward_val(rs2_addr_p1, rs2_data_p1, out_valid && out_reg_we, out_rd_addr,
                          out_result, wb_we, wb_rd, wb_data);
    alu_A  = '0;
    alu_B  = '0;
    alu_op = ALU_ADD;
    if (vld_p1) begin
      alu_A  = use_pc_p1  ? pc_p1  : fwd_rs1;
      alu_B  = use_imm_p1 ? imm_p1 : fwd_rs2;
      alu_op = op_p1;
    end
  end

  // ---- stage p1: ID/EX register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rs1_addr_p1 <= '0;
      rs2_addr_p1 <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      op_p1       <= ALU_ADD;
      use_pc_p1   <= 1'b0;
      use_imm_p1  <= 1'b0;
      rd_addr_p1  <= '0;
      reg_we_p1   <= 1'b0;
    end else begin
      if (flush) vld_p1 <= 1'b0;
      else if (in_ready) vld_p1 <= in_valid;
      if (accept) begin
        pc_p1       <= in_pc;
        rs1_addr_p1 <= in_rs1_addr;
        rs2_addr_p1 <= in_rs2_addr;
        rs1_data_p1 <= in_rs1_data;
        rs2_data_p1 <= in_rs2_data;
        imm_p1      <= in_imm;
        op_p1       <= in_alu_op;
        use_pc_p1   <= in_use_pc;
        use_imm_p1  <= in_use_imm;
        rd_addr_p1  <= in_rd_addr;
        reg_we_p1   <= in_reg_we;
      end
    end
  end

  // ---- stage p2: EX/MEM register (drives out_*) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_store_data <= '0;
      out_rd_addr    <= '0;
      out_reg_we     <= 1'b0;
      out_flags      <= '0;
    end else if (s2_advance && !flush) begin
      out_valid      <= 1'b1;
      out_result     <= alu_result;
      out_store_data <= fwd_rs2;
      out_rd_addr    <= rd_addr_p1;
      out_reg_we     <= reg_we_p1;
      out_flags      <= {alu_Z, alu_N, alu_C, alu_V};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_v_ex_stage.sv
// Directed bench for v_ex_stage: an ALU model closes the loop, and a queue of
// architecturally expected results is checked at every output handshake.
module tb_v_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [3:0]  in_alu_op;
  logic        in_use_pc, in_use_imm, in_reg_we;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] alu_A, alu_B, alu_result;
  logic [3:0]  alu_op;
  logic        alu_Z, alu_N, alu_C, alu_V;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd_addr;
  logic        out_reg_we;
  logic [3:0]  out_flags;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [31:0] d1;
    logic [4:0]  rs2;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        upc;
    logic        uimm;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] a;     // architectural value rs1 must resolve to
    logic [31:0] b;     // architectural value rs2 must resolve to
    logic        kill;  // never reaches the output
    logic        fl;    // flush asserted while presenting this one
  } ins_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] st;
    logic [3:0]  fl;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t exp_q[$];

  v_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_op(in_alu_op), .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
    .in_rd_addr(in_rd_addr), .in_reg_we(in_reg_we), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_result(alu_result),
    .alu_Z(alu_Z), .alu_N(alu_N), .alu_C(alu_C), .alu_V(alu_V),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd_addr(out_rd_addr),
    .out_reg_we(out_reg_we), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; returns {Z,N,C,V,result}
  function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = '0;
    endcase
    return {(r == 32'd0), r[31], c, v, r};
  endfunction

  assign {alu_Z, alu_N, alu_C, alu_V, alu_result} = alu_ref(alu_op, alu_A, alu_B);

  function automatic ins_t mk(input logic [31:0] pc, input int rs1, input logic [31:0] d1,
                              input int rs2, input logic [31:0] d2, input logic [31:0] imm,
                              input int op, input int upc, input int uimm, input int rd,
                              input int we, input logic [31:0] a, input logic [31:0] b,
                              input int kill, input int fl);
    ins_t e;
    e.pc = pc; e.rs1 = 5'(rs1); e.d1 = d1; e.rs2 = 5'(rs2); e.d2 = d2; e.imm = imm;
    e.op = 4'(op); e.upc = (upc != 0); e.uimm = (uimm != 0); e.rd = 5'(rd);
    e.we = (we != 0); e.a = a; e.b = b; e.kill = (kill != 0); e.fl = (fl != 0);
    return e;
  endfunction

  function automatic exp_t model(input ins_t e);
    exp_t x;
    logic [35:0] r;
    r = alu_ref(e.op, e.upc ? e.pc : e.a, e.uimm ? e.imm : e.b);
    x.res = r[31:0]; x.fl = r[35:32]; x.st = e.b; x.rd = e.rd; x.we = e.we;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input ins_t e);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_pc = e.pc; in_rs1_addr = e.rs1; in_rs1_data = e.d1;
    in_rs2_addr = e.rs2; in_rs2_data = e.d2; in_imm = e.imm; in_alu_op = e.op;
    in_use_pc = e.upc; in_use_imm = e.uimm; in_rd_addr = e.rd; in_reg_we = e.we;
    flush = e.fl;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (e.fl) chk("flush_in_ready", 32'(in_ready), 32'd1);
      ok = in_ready;
      @(posedge clk);
    end
    #1;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 40 cycles");
    end else if (!e.kill) begin
      exp_q.push_back(model(e));
    end
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  // Output checker: handshakes pop the expected queue; stalls must hold s2.
  exp_t hold;
  bit   prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_result", out_result, hold.res);
        chk("stall_flags", 32'(out_flags), 32'(hold.fl));
        chk("stall_rd", 32'(out_rd_addr), 32'(hold.rd));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: got result %h, required no output", out_result);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk("result", out_result, x.res);
          chk("flags", 32'(out_flags), 32'(x.fl));
          chk("store_data", out_store_data, x.st);
          chk("rd_addr", 32'(out_rd_addr), 32'(x.rd));
          chk("reg_we", 32'(out_reg_we), 32'(x.we));
        end
      end
      prev_stall = out_valid && !out_ready;
      hold.res = out_result; hold.fl = out_flags; hold.rd = out_rd_addr;
      hold.st = out_store_data; hold.we = out_reg_we;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_rs1_addr = '0; in_rs2_addr = '0; in_rs1_data = '0; in_rs2_data = '0;
    in_imm = '0; in_alu_op = '0; in_use_pc = 1'b0; in_use_imm = 1'b0; in_rd_addr = '0;
    in_reg_we = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_A", alu_A, 32'd0);
    rst = 1'b0;
    idle(1);

    // back-to-back independent ops, with literal pins on the first two
    send(mk(32'h100, 11, 5, 12, 7, 0, 0, 0, 0, 1, 1, 5, 7, 0, 0));
    send(mk(32'h104, 13, 3, 14, 10, 0, 1, 0, 0, 2, 1, 3, 10, 0, 0));
    @(negedge clk);
    chk("lit_add_valid", 32'(out_valid), 32'd1);
    chk("lit_add_result", out_result, 32'd12);
    chk("lit_add_flags", 32'(out_flags), 32'h0);
    @(negedge clk);
    chk("lit_sub_result", out_result, 32'hFFFF_FFF9);
    chk("lit_sub_flags", 32'(out_flags), 32'b0100);
    idle(1);
    send(mk(32'h200, 20, 77, 0, 0, 32'h10, 0, 1, 1, 13, 1, 77, 0, 0, 0));
    send(mk(32'h204, 21, 32'hF0F0, 22, 32'h0FF0, 0, 4, 0, 0, 14, 1, 32'hF0F0, 32'h0FF0, 0, 0));
    send(mk(32'h208, 23, 5, 24, 5, 0, 1, 0, 0, 15, 0, 5, 5, 0, 0));
    idle(3);

    // EX/MEM forwarding with stale register-file data
    send(mk(32'h300, 15, 1, 16, 2, 0, 0, 0, 0, 3, 1, 1, 2, 0, 0));
    send(mk(32'h304, 3, 0, 3, 0, 0, 0, 0, 0, 4, 1, 3, 3, 0, 0));
    idle(3);

    // writeback forwarding and priority
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'd100;
    send(mk(32'h400, 0, 0, 0, 0, 42, 0, 0, 1, 5, 1, 0, 0, 0, 0));
    send(mk(32'h404, 5, 9, 0, 0, 0, 0, 0, 1, 7, 1, 42, 0, 0, 0));
    send(mk(32'h408, 0, 0, 0, 0, 1, 0, 0, 1, 6, 1, 0, 0, 0, 0));
    send(mk(32'h40C, 5, 9, 5, 9, 0, 0, 0, 0, 8, 1, 100, 100, 0, 0));
    idle(1);
    wb_rd = 5'd0;
    send(mk(32'h410, 0, 7, 0, 8, 0, 0, 0, 0, 9, 1, 7, 8, 0, 0));
    send(mk(32'h414, 0, 0, 0, 0, 55, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    send(mk(32'h418, 0, 3, 0, 5, 1, 0, 0, 1, 12, 1, 3, 5, 0, 0));
    idle(1);
    wb_we = 1'b0;
    idle(3);

    // backpressure: three queued instructions, forwarding across the stall
    out_ready = 1'b0;
    fork
      begin
        send(mk(32'h500, 0, 0, 0, 0, 10, 0, 0, 1, 14, 1, 0, 0, 0, 0));
        send(mk(32'h504, 14, 0, 0, 0, 20, 0, 0, 1, 15, 1, 10, 0, 0, 0));
        send(mk(32'h508, 15, 0, 0, 0, 30, 0, 0, 1, 16, 1, 30, 0, 0, 0));
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(4);

    // flush: held instruction and the one presented alongside both die
    send(mk(32'h600, 0, 0, 0, 0, 1, 0, 0, 1, 17, 1, 0, 0, 1, 0));
    send(mk(32'h604, 0, 0, 0, 0, 2, 0, 0, 1, 18, 1, 0, 0, 1, 1));
    send(mk(32'h608, 17, 5, 0, 0, 2, 0, 0, 1, 19, 1, 5, 0, 0, 0));
    idle(4);

    // reset mid-stream with both registers full and downstream stalled
    out_ready = 1'b0;
    send(mk(32'h700, 0, 0, 0, 0, 11, 0, 0, 1, 20, 1, 0, 0, 1, 0));
    send(mk(32'h704, 0, 0, 0, 0, 12, 1, 0, 1, 21, 1, 0, 0, 1, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_result", out_result, 32'd0);
    chk("mid_rst_out_flags", 32'(out_flags), 32'd0);
    chk("mid_rst_store", out_store_data, 32'd0);
    chk("mid_rst_rd", 32'(out_rd_addr), 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rst_alu_B", alu_B, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(mk(32'h800, 1, 8, 0, 0, 1, 0, 0, 1, 22, 1, 8, 0, 0, 0));
    idle(6);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
